// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Purpose  : Shared constants and the multiply-controller state encoding.
// Revision : 1.0
// ============================================================================
package pipeline_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int MULT_ITERS    = WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_RUN  = 2'd1,
    MULT_SIGN = 2'd2
  } mult_state_e;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/mult_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : mult_shift_add
// Purpose  : Magnitude shift-add multiply datapath with final sign correction.
// Revision : 1.0
// ============================================================================
module mult_shift_add
  import pipeline_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 finalize_i,
  input  logic                 sign_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   product_o
);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_addend;

  // The magnitude of the most negative value is exactly 2^(WIDTH-1), which
  // still fits in WIDTH unsigned bits.
  assign w_mag_a  = (sign_i && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
  assign w_mag_b  = (sign_i && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;
  assign w_addend = mplier_q[0] ? mcand_q : '0;

  assign product_o = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, w_mag_a};
      mplier_d = w_mag_b;
      acc_d    = '0;
      neg_d    = sign_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end else if (step_i) begin
      acc_d    = acc_q + w_addend;
      mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
    end else if (finalize_i) begin
      acc_d = product_o;
      neg_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
    end
  end

endmodule : mult_shift_add
`default_nettype wire

// File: rtl/mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_ctrl
// Purpose  : Iterative multiply sequencer owning HI/LO, done and pipeline stall.
// Revision : 1.0
// ============================================================================
module mult_ctrl
  import pipeline_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] srca_e,
  input  logic [WIDTH-1:0] srcb_e,
  input  logic             mf_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall_mult
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mult_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               w_load;
  logic               w_step;
  logic               w_finalize;
  logic [2*WIDTH-1:0] w_product;

  mult_shift_add #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .load_i     (w_load),
    .step_i     (w_step),
    .finalize_i (w_finalize),
    .sign_i     (mult_sign),
    .a_i        (srca_e),
    .b_i        (srcb_e),
    .product_o  (w_product)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_finalize = 1'b0;
    case (state_q)
      MULT_IDLE: begin
        if (start_mult) begin
          w_load  = 1'b1;
          cnt_d   = '0;
          state_d = MULT_RUN;
        end
      end
      MULT_RUN: begin
        w_step = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = MULT_SIGN;
        end
      end
      MULT_SIGN: begin
        w_finalize = 1'b1;
        state_d    = MULT_IDLE;
      end
      default: begin
        state_d = MULT_IDLE;
      end
    endcase
  end

  // HI/LO move only on the SIGN -> IDLE edge; done marks that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MULT_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= w_finalize;
      if (w_finalize) begin
        hi_q <= w_product[2*WIDTH-1:WIDTH];
        lo_q <= w_product[WIDTH-1:0];
      end
    end
  end

  assign hi         = hi_q;
  assign lo         = lo_q;
  assign done       = done_q;
  assign busy       = (state_q != MULT_IDLE);
  assign stall_mult = busy & (mf_req | start_mult);

endmodule : mult_ctrl
`default_nettype wire

// File: tb/tb_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_ctrl
// Purpose  : Self-checking bench for mult_ctrl against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_mult_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        mult_sign;
  logic [31:0] srca_e;
  logic [31:0] srcb_e;
  logic        mf_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall_mult;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] exp_p    = '0;

  mult_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .mult_sign  (mult_sign),
    .srca_e     (srca_e),
    .srcb_e     (srcb_e),
    .mf_req     (mf_req),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .stall_mult (stall_mult)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at the negedge after the accepting edge with start_mult low.
  // Step k is the k-th negedge after acceptance; done must appear at k=34.
  task automatic track(input logic [63:0] newp);
    logic m;
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge clk);
      chk("busy", 64'(busy), 64'(k <= 33));
      chk("done", 64'(done), 64'(k == 34));
      if (k == 34) exp_p = newp;
      chk("hi", 64'(hi), 64'(exp_p[63:32]));
      chk("lo", 64'(lo), 64'(exp_p[31:0]));
      m = 1'($urandom_range(0, 1));
      mf_req = m;
      #1;
      chk("stall", 64'(stall_mult), 64'((k <= 33) && m));
    end
    mf_req = 1'b0;
  endtask

  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    start_mult = 1'b1;
    srca_e     = a;
    srcb_e     = b;
    mult_sign  = s;
    #1;
    chk("stall_idle", 64'(stall_mult), 64'(0));
    @(negedge clk);
    start_mult = 1'b0;
    srca_e     = $urandom;
    srcb_e     = $urandom;
    mult_sign  = 1'($urandom_range(0, 1));
    track(ref_prod(a, b, s));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    reset      = 1'b1;
    start_mult = 1'b0;
    mult_sign  = 1'b0;
    srca_e     = '0;
    srcb_e     = '0;
    mf_req     = 1'b0;
    #1;
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_stall", 64'(stall_mult), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    mf_req = 1'b1;
    #1;
    chk("idle_mf_nostall", 64'(stall_mult), 64'(0));
    mf_req = 1'b0;

    do_mult(32'd7, 32'd6, 1'b0);
    chk("u7x6_lo", 64'(lo), 64'h2A);
    do_mult(32'hFFFFFFFD, 32'd5, 1'b1);
    chk("s-3x5", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    do_mult(32'h80000000, 32'h80000000, 1'b1);
    chk("smin_sq", {hi, lo}, 64'h40000000_00000000);
    do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("umax_sq", {hi, lo}, 64'hFFFFFFFE_00000001);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      rs = 1'($urandom_range(0, 1));
      do_mult(ra, rb, rs);
    end

    // Contention: second start and mf_req raised at cycle 10 of 3 x 4.
    @(negedge clk);
    start_mult = 1'b1; srca_e = 32'd3; srcb_e = 32'd4; mult_sign = 1'b0;
    @(negedge clk);
    start_mult = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 10) begin
        start_mult = 1'b1; mf_req = 1'b1;
        srca_e = 32'd9; srcb_e = 32'd9; mult_sign = 1'b0;
      end
      #1;
      if (k >= 10) chk("cont_stall", 64'(stall_mult), 64'(k <= 33));
      if (k < 34) chk("cont_hold_lo", 64'(lo), 64'(exp_p[31:0]));
    end
    exp_p = 64'd12;
    chk("cont_done", 64'(done), 64'(1));
    chk("cont_busy", 64'(busy), 64'(0));
    chk("cont_hilo", {hi, lo}, 64'd12);
    @(negedge clk);
    start_mult = 1'b0;
    mf_req     = 1'b0;
    track(64'd81);
    chk("cont_81", {hi, lo}, 64'd81);

    // Asynchronous reset in the middle of 100 x 200.
    @(negedge clk);
    start_mult = 1'b1; srca_e = 32'd100; srcb_e = 32'd200; mult_sign = 1'b0;
    @(negedge clk);
    start_mult = 1'b0;
    mf_req     = 1'b1;
    for (int k = 2; k <= 15; k++) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_stall", 64'(stall_mult), 64'(0));
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
    exp_p = '0;
    @(negedge clk);
    reset  = 1'b0;
    mf_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("post_rst_done", 64'(done), 64'(0));
      chk("post_rst_lo", 64'(lo), 64'(0));
    end
    do_mult(32'd2, 32'd3, 1'b0);
    chk("after_rst_2x3", 64'(lo), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_mult_ctrl
`default_nettype wire
